// File: rtl/ecc_apb_responder_pkg.sv
// Shared constants and types for the ECC APB responder:
// register offsets, op/width encodings and STATUS layout.
package ecc_pkg;

  localparam int AMBA_AW_DEF = 20;
  localparam int AMBA_DW_DEF = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 64;

  localparam logic [4:0] OFF_CTRL  = 5'h00;
  localparam logic [4:0] OFF_DIN   = 5'h04;
  localparam logic [4:0] OFF_WIDTH = 5'h08;
  localparam logic [4:0] OFF_NOISE = 5'h0C;
  localparam logic [4:0] OFF_DOUT  = 5'h10;
  localparam logic [4:0] OFF_STAT  = 5'h14;

  typedef enum logic [1:0] {
    OP_ENC  = 2'd0,
    OP_DEC  = 2'd1,
    OP_FULL = 2'd2
  } op_e;
  localparam logic [1:0] OP_RSVD = 2'd3;

  typedef enum logic [1:0] {
    CW8  = 2'd0,
    CW16 = 2'd1,
    CW32 = 2'd2
  } width_e;
  localparam logic [1:0] CW_RSVD = 2'd3;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_TMO  = 2;
  localparam int ST_NERR = 3;
  localparam int ST_W    = 5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/ecc_apb_responder_if.sv
// APB3 completer-side bus bundle for the ECC responder.
// Parameterised so the address and data widths track the top.
interface ecc_apb_if #(
  parameter int AW = 20,
  parameter int DW = 32
) ();
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ecc_apb_responder_seq.sv
// Operation sequencer: launches the core, waits for valid or
// timeout, and latches the result and status flags.
module ecc_op_sequencer
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  launch,
  input  logic                  core_valid,
  input  logic [DATA_WIDTH-1:0] core_data_out,
  input  logic [1:0]            core_num_err,
  output logic                  core_start,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [1:0]            num_err,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  seq_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  start_q, start_d;
  logic                  done_q, done_d;
  logic                  tmo_q, tmo_d;
  logic [1:0]            nerr_q, nerr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    done_d  = done_q;
    tmo_d   = tmo_q;
    nerr_d  = nerr_q;
    dout_d  = dout_q;
    unique case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_RUN;
          start_d = 1'b1;
          cnt_d   = '0;
          done_d  = 1'b0;
          tmo_d   = 1'b0;
          nerr_d  = 2'd0;
        end
      end
      S_RUN: begin
        // A valid in the last counted cycle still wins over timeout
        if (core_valid) begin
          state_d = S_IDLE;
          dout_d  = core_data_out;
          nerr_d  = core_num_err;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      nerr_q  <= 2'd0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      nerr_q  <= nerr_d;
      dout_q  <= dout_d;
    end
  end

  assign core_start = start_q;
  assign busy       = (state_q == S_RUN);
  assign done       = done_q;
  assign timeout    = tmo_q;
  assign num_err    = nerr_q;
  assign data_out   = dout_q;

endmodule

// File: rtl/ecc_apb_responder.sv
// APB3 register file fronting the ECC core: address decode,
// config registers, read mux and the operation sequencer.
module ecc_apb_responder
  import ecc_pkg::*;
#(
  parameter int AMBA_ADDR_WIDTH = AMBA_AW_DEF,
  parameter int AMBA_WORD       = AMBA_DW_DEF,
  parameter int DATA_WIDTH      = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  ecc_apb_if.slave              apb,
  output logic [DATA_WIDTH-1:0] core_data_in,
  output logic [DATA_WIDTH-1:0] core_noise,
  output logic [1:0]            core_width,
  output logic [1:0]            core_op,
  output logic                  core_start,
  input  logic                  core_valid,
  input  logic [DATA_WIDTH-1:0] core_data_out,
  input  logic [1:0]            core_num_err
);

  logic [AMBA_ADDR_WIDTH-1:0] paddr;
  logic [AMBA_WORD-1:0]       pwdata;
  logic [AMBA_WORD-1:0]       rd_val;
  logic [4:0]                 off;
  logic                       hi_ok;
  logic                       h_ctrl, h_din, h_width;
  logic                       h_noise, h_dout, h_stat;
  logic                       setup, access, pready;
  logic                       err, wr_en, launch;
  logic                       busy, done, timeout;
  logic [1:0]                 num_err;
  logic [DATA_WIDTH-1:0]      data_out;
  logic [ST_W-1:0]            status;

  op_e                   ctrl_q, ctrl_d;
  width_e                width_q, width_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] noise_q, noise_d;
  logic [AMBA_WORD-1:0]  prdata_q, prdata_d;

  assign paddr  = apb.PADDR;
  assign pwdata = apb.PWDATA;
  assign off    = paddr[4:0];
  assign hi_ok  = ~|paddr[AMBA_ADDR_WIDTH-1:5];

  assign h_ctrl  = hi_ok & (off == OFF_CTRL);
  assign h_din   = hi_ok & (off == OFF_DIN);
  assign h_width = hi_ok & (off == OFF_WIDTH);
  assign h_noise = hi_ok & (off == OFF_NOISE);
  assign h_dout  = hi_ok & (off == OFF_DOUT);
  assign h_stat  = hi_ok & (off == OFF_STAT);

  assign setup  = apb.PSEL & ~apb.PENABLE;
  assign access = apb.PSEL & apb.PENABLE;
  // Only writes wait out a running operation; reads never stall
  assign pready = access & ~(apb.PWRITE & busy);

  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_DONE] = done;
    status[ST_TMO]  = timeout;
    status[ST_NERR +: 2] = num_err;
  end

  always_comb begin
    err    = 1'b0;
    rd_val = '0;
    unique case (1'b1)
      h_ctrl: begin
        rd_val = AMBA_WORD'(ctrl_q);
        err    = apb.PWRITE & (pwdata[1:0] == OP_RSVD);
      end
      h_din:   rd_val = AMBA_WORD'(din_q);
      h_width: begin
        rd_val = AMBA_WORD'(width_q);
        err    = apb.PWRITE & (pwdata[1:0] == CW_RSVD);
      end
      h_noise: rd_val = AMBA_WORD'(noise_q);
      h_dout: begin
        rd_val = AMBA_WORD'(data_out);
        err    = apb.PWRITE;
      end
      h_stat: begin
        rd_val = AMBA_WORD'(status);
        err    = apb.PWRITE;
      end
      default: err = 1'b1;
    endcase
  end

  assign wr_en  = pready & apb.PWRITE & ~err;
  assign launch = wr_en & h_ctrl;

  always_comb begin
    ctrl_d   = ctrl_q;
    din_d    = din_q;
    width_d  = width_q;
    noise_d  = noise_q;
    prdata_d = prdata_q;
    if (wr_en) begin
      unique case (1'b1)
        h_ctrl:  ctrl_d  = op_e'(pwdata[1:0]);
        h_din:   din_d   = DATA_WIDTH'(pwdata);
        h_width: width_d = width_e'(pwdata[1:0]);
        h_noise: noise_d = DATA_WIDTH'(pwdata);
        default: ;
      endcase
    end
    if (setup & ~apb.PWRITE) begin
      prdata_d = rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= OP_ENC;
      din_q    <= '0;
      width_q  <= CW8;
      noise_q  <= '0;
      prdata_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      din_q    <= din_d;
      width_q  <= width_d;
      noise_q  <= noise_d;
      prdata_q <= prdata_d;
    end
  end

  ecc_op_sequencer #(
    .DATA_WIDTH     (DATA_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_seq (
    .clk           (clk),
    .rst           (rst),
    .launch        (launch),
    .core_valid    (core_valid),
    .core_data_out (core_data_out),
    .core_num_err  (core_num_err),
    .core_start    (core_start),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .num_err       (num_err),
    .data_out      (data_out)
  );

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = pready;
  assign apb.PSLVERR = pready & err;

  assign core_data_in = din_q;
  assign core_noise   = noise_q;
  assign core_width   = width_q;
  assign core_op      = ctrl_q;

endmodule

// File: tb/tb_ecc_apb_responder.sv
// Self-checking bench for ecc_apb_responder against a
// transaction-level register model.
module tb_ecc_apb_responder;

  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ecc_apb_if #(.AW(20), .DW(32)) apb ();

  logic [31:0] core_data_in, core_noise, core_data_out;
  logic [1:0]  core_width, core_op, core_num_err;
  logic        core_start, core_valid;

  ecc_apb_responder dut (
    .clk           (clk),
    .rst           (rst),
    .apb           (apb),
    .core_data_in  (core_data_in),
    .core_noise    (core_noise),
    .core_width    (core_width),
    .core_op       (core_op),
    .core_start    (core_start),
    .core_valid    (core_valid),
    .core_data_out (core_data_out),
    .core_num_err  (core_num_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (core_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
  end

  // Register model
  logic [1:0]  m_ctrl, m_width, m_nerr;
  logic [31:0] m_din, m_noise, m_dout;
  logic        m_done, m_tmo;

  task automatic m_reset();
    m_ctrl = 0; m_width = 0; m_nerr = 0;
    m_din = 0; m_noise = 0; m_dout = 0;
    m_done = 0; m_tmo = 0;
  endtask

  function automatic bit m_mapped(logic [19:0] a);
    return a == 20'h0 || a == 20'h4 || a == 20'h8 ||
           a == 20'hC || a == 20'h10 || a == 20'h14;
  endfunction

  function automatic bit m_err(logic [19:0] a, bit w, logic [31:0] d);
    if (!m_mapped(a)) return 1;
    if (!w) return 0;
    if (a == 20'h10 || a == 20'h14) return 1;
    if ((a == 20'h0 || a == 20'h8) && d[1:0] == 2'd3) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_rd(logic [19:0] a);
    case (a)
      20'h0:  return 32'(m_ctrl);
      20'h4:  return m_din;
      20'h8:  return 32'(m_width);
      20'hC:  return m_noise;
      20'h10: return m_dout;
      20'h14: return 32'(m_nerr) * 8 + 32'(m_tmo) * 4 + 32'(m_done) * 2;
      default: return 0;
    endcase
  endfunction

  task automatic m_write(logic [19:0] a, logic [31:0] d);
    if (m_err(a, 1, d)) return;
    case (a)
      20'h0: begin
        m_ctrl = d[1:0]; m_done = 0; m_tmo = 0; m_nerr = 0;
      end
      20'h4: m_din = d;
      20'h8: m_width = d[1:0];
      20'hC: m_noise = d;
      default: ;
    endcase
  endtask

  // Bus drivers
  task automatic apb_write(input logic [19:0] a, input logic [31:0] d,
                           output logic err, output int stall,
                           output bit din_moved, output int ccyc);
    logic [31:0] din0;
    @(posedge clk); #1;
    apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = 1;
    apb.PADDR = a; apb.PWDATA = d;
    @(posedge clk); #1;
    apb.PENABLE = 1;
    #3;
    stall = 0; din_moved = 0; din0 = core_data_in;
    while (apb.PREADY !== 1'b1 && stall < 300) begin
      @(posedge clk); #4;
      stall++;
      if (core_data_in !== din0) din_moved = 1;
    end
    if (stall >= 300) begin
      checks++; errors++;
      $display("FAIL apb_write_timeout addr=%h got PREADY=%b exp 1", a, apb.PREADY);
    end
    err = apb.PSLVERR;
    @(posedge clk); #1;
    ccyc = cyc;
    apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0;
  endtask

  task automatic apb_read(input logic [19:0] a, output logic [31:0] d,
                          output logic rdy, output logic err);
    @(posedge clk); #1;
    apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = a;
    @(posedge clk); #1;
    apb.PENABLE = 1;
    #3;
    d = apb.PRDATA; rdy = apb.PREADY; err = apb.PSLVERR;
    @(posedge clk); #1;
    apb.PSEL = 0; apb.PENABLE = 0;
  endtask

  task automatic core_respond(input int dly, input logic [31:0] data,
                              input logic [1:0] ne);
    int n = 0;
    while (core_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL core_start_wait got 0 exp 1");
    end else begin
      repeat (dly) @(posedge clk);
      #1;
      core_valid = 1; core_data_out = data; core_num_err = ne;
      @(posedge clk); #1;
      core_valid = 0; core_data_out = $urandom; core_num_err = 0;
    end
  endtask

  // Tests
  task automatic test_reset();
    logic [31:0] d; logic r, e;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    m_reset();
    for (int i = 0; i < 6; i++) begin
      apb_read(20'(i * 4), d, r, e);
      checks++;
      if (d !== 0) begin errors++; $display("FAIL reset_prdata a=%0h got %h exp 0", i*4, d); end
      checks++;
      if (r !== 1) begin errors++; $display("FAIL reset_pready a=%0h got %b exp 1", i*4, r); end
      checks++;
      if (e !== 0) begin errors++; $display("FAIL reset_pslverr a=%0h got %b exp 0", i*4, e); end
    end
    checks++;
    if ({core_data_in, core_noise, core_width, core_op, core_start} !== 0) begin
      errors++;
      $display("FAIL reset_core_outs got %h exp 0",
               {core_data_in, core_noise, core_width, core_op, core_start});
    end
  endtask

  task automatic test_regs();
    logic [31:0] d, rd; logic [19:0] a; logic e, r; int s, cc; bit mv;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 2))
        0: a = 20'h4;
        1: a = 20'h8;
        default: a = 20'hC;
      endcase
      d = $urandom;
      if (a == 20'h8) d[1:0] = 2'($urandom_range(0, 2));
      apb_write(a, d, e, s, mv, cc);
      m_write(a, d);
      checks++;
      if (e !== 0) begin errors++; $display("FAIL regs_wr_err a=%h got %b exp 0", a, e); end
      a = 20'($urandom_range(0, 5) * 4);
      apb_read(a, rd, r, e);
      checks++;
      if (rd !== m_rd(a)) begin errors++; $display("FAIL regs_rd a=%h got %h exp %h", a, rd, m_rd(a)); end
      checks++;
      if ({core_data_in, core_noise, core_width} !== {m_din, m_noise, m_width}) begin
        errors++;
        $display("FAIL regs_core_outs got %h/%h/%h exp %h/%h/%h",
                 core_data_in, core_noise, core_width, m_din, m_noise, m_width);
      end
    end
  endtask

  task automatic test_encode();
    logic [31:0] rd; logic e, r; int s, cc, sc0; bit mv;
    apb_write(20'h4, 32'hA5, e, s, mv, cc); m_write(20'h4, 32'hA5);
    apb_write(20'h8, 32'h0, e, s, mv, cc);  m_write(20'h8, 0);
    apb_write(20'hC, 32'h0, e, s, mv, cc);  m_write(20'hC, 0);
    sc0 = start_cnt;
    fork
      apb_write(20'h0, 32'h0, e, s, mv, cc);
      core_respond(3, 32'h5A, 2'd0);
    join
    m_write(20'h0, 0);
    m_dout = 32'h5A; m_nerr = 0; m_done = 1;
    checks++;
    if (start_cyc !== cc) begin errors++; $display("FAIL enc_start_cycle got %0d exp %0d", start_cyc, cc); end
    checks++;
    if (start_cnt - sc0 !== 1) begin errors++; $display("FAIL enc_start_width got %0d exp 1", start_cnt - sc0); end
    apb_read(20'h10, rd, r, e);
    checks++;
    if (rd !== 32'h5A) begin errors++; $display("FAIL enc_dout got %h exp 5a", rd); end
    apb_read(20'h14, rd, r, e);
    checks++;
    if (rd !== 32'h02) begin errors++; $display("FAIL enc_status got %h exp 02", rd); end
  endtask

  task automatic test_ops();
    logic [31:0] rd, din, res; logic [1:0] op, ne; logic e, r;
    int s, cc, sc0, dly; bit mv;
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom_range(0, 2)); ne = 2'($urandom_range(0, 2));
      din = $urandom; res = $urandom; dly = $urandom_range(0, 8);
      apb_write(20'h4, din, e, s, mv, cc); m_write(20'h4, din);
      sc0 = start_cnt;
      fork
        apb_write(20'h0, 32'(op), e, s, mv, cc);
        core_respond(dly, res, ne);
      join
      m_write(20'h0, 32'(op));
      m_dout = res; m_nerr = ne; m_done = 1;
      checks++;
      if (start_cnt - sc0 !== 1 || core_op !== m_ctrl) begin
        errors++;
        $display("FAIL ops_launch got %0d/%0d exp 1/%0d", start_cnt - sc0, core_op, m_ctrl);
      end
      apb_read(20'h10, rd, r, e);
      checks++;
      if (rd !== m_rd(20'h10)) begin errors++; $display("FAIL ops_dout got %h exp %h", rd, m_rd(20'h10)); end
      apb_read(20'h14, rd, r, e);
      checks++;
      if (rd !== m_rd(20'h14)) begin errors++; $display("FAIL ops_status got %h exp %h", rd, m_rd(20'h14)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, nd, res; logic e, e2, r; int s, s2, cc, dly; bit mv, mv2;
    dly = $urandom_range(3, 12); nd = $urandom; res = $urandom;
    fork
      begin
        apb_write(20'h0, 32'h2, e, s, mv, cc);
        apb_write(20'h4, nd, e2, s2, mv2, cc);
      end
      core_respond(dly, res, 2'd1);
    join
    m_write(20'h0, 2); m_dout = res; m_nerr = 1; m_done = 1;
    m_write(20'h4, nd);
    // Access phase of the second write opens two cycles after start
    checks++;
    if (s2 !== dly - 1) begin errors++; $display("FAIL b2b_stall got %0d exp %0d", s2, dly - 1); end
    checks++;
    if (mv2 !== 0) begin errors++; $display("FAIL b2b_din_stable got %b exp 0", mv2); end
    checks++;
    if (e2 !== 0 || core_data_in !== nd) begin
      errors++;
      $display("FAIL b2b_commit got err=%b din=%h exp 0/%h", e2, core_data_in, nd);
    end
    apb_read(20'h14, rd, r, e);
    checks++;
    if (rd !== 32'h0A) begin errors++; $display("FAIL b2b_status got %h exp 0a", rd); end
    apb_read(20'h4, rd, r, e);
    checks++;
    if (rd !== nd) begin errors++; $display("FAIL b2b_din_rd got %h exp %h", rd, nd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, d; logic [19:0] a; logic e, r; int s, cc, sc0; bit mv;
    sc0 = start_cnt;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      case (i)
        0: a = 20'h10;
        1: a = 20'h14;
        2: begin a = 20'h0; d[1:0] = 2'd3; end
        3: begin a = 20'h8; d[1:0] = 2'd3; end
        4: a = 20'h18;
        default: a = 20'(($urandom_range(1, 255) << 8) | 4);
      endcase
      apb_write(a, d, e, s, mv, cc);
      m_write(a, d);
      checks++;
      if (e !== 1) begin errors++; $display("FAIL err_wr a=%h got %b exp 1", a, e); end
    end
    apb_read(20'h18, rd, r, e);
    checks++;
    if ({rd, r, e} !== {32'h0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL err_rd18 got %h/%b/%b exp 0/1/1", rd, r, e);
    end
    apb_read(20'h1006, rd, r, e);
    checks++;
    if ({rd, e} !== {32'h0, 1'b1}) begin errors++; $display("FAIL err_rd_hi got %h/%b exp 0/1", rd, e); end
    for (int i = 0; i < 6; i++) begin
      apb_read(20'(i * 4), rd, r, e);
      checks++;
      if ({rd, e} !== {m_rd(20'(i * 4)), 1'b0}) begin
        errors++; $display("FAIL err_regs a=%0h got %h/%b exp %h/0", i*4, rd, e, m_rd(20'(i * 4)));
      end
    end
    checks++;
    if (start_cnt !== sc0) begin errors++; $display("FAIL err_no_start got %0d exp %0d", start_cnt, sc0); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd, nz; logic e, e2, r; int s, s2, cc; bit mv;
    nz = $urandom;
    apb_write(20'h0, 32'h1, e, s, mv, cc);
    m_write(20'h0, 1);
    apb_write(20'hC, nz, e2, s2, mv, cc);
    m_tmo = 1; m_write(20'hC, nz);
    checks++;
    if (s2 !== TMO - 2) begin errors++; $display("FAIL tmo_busy_len got %0d exp %0d", s2, TMO - 2); end
    apb_read(20'h14, rd, r, e);
    checks++;
    if (rd !== 32'h04) begin errors++; $display("FAIL tmo_status got %h exp 04", rd); end
    apb_read(20'h10, rd, r, e);
    checks++;
    if (rd !== m_dout) begin errors++; $display("FAIL tmo_dout got %h exp %h", rd, m_dout); end
    checks++;
    if ({core_noise, core_op} !== {nz, 2'd1}) begin
      errors++; $display("FAIL tmo_core_outs got %h/%0d exp %h/1", core_noise, core_op, nz);
    end
  endtask

  task automatic test_reset_run();
    logic [31:0] rd; logic e, r; int s, cc, sc0; bit mv;
    apb_write(20'h4, $urandom, e, s, mv, cc);
    apb_write(20'h0, 32'h0, e, s, mv, cc);
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    m_reset();
    sc0 = start_cnt;
    repeat (2) @(posedge clk);
    #1 core_valid = 1; core_data_out = 32'hDEAD_BEEF; core_num_err = 2;
    @(posedge clk); #1 core_valid = 0; core_num_err = 0;
    repeat (5) @(posedge clk);
    apb_read(20'h14, rd, r, e);
    checks++;
    if (rd !== 0) begin errors++; $display("FAIL rstrun_status got %h exp 0", rd); end
    apb_read(20'h10, rd, r, e);
    checks++;
    if (rd !== 0) begin errors++; $display("FAIL rstrun_dout got %h exp 0", rd); end
    checks++;
    if (start_cnt !== sc0 || core_data_in !== 0) begin
      errors++; $display("FAIL rstrun_quiet got %0d/%h exp %0d/0", start_cnt, core_data_in, sc0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0;
    apb.PADDR = 0; apb.PWDATA = 0;
    core_valid = 0; core_data_out = 0; core_num_err = 0;
    test_reset();
    test_regs();
    test_encode();
    test_ops();
    test_back_to_back();
    test_errors();
    test_timeout();
    test_reset_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
